// File: rtl/seg_display_arbiter.sv
// ============================================================================
// Module   : seg_display_arbiter
// Brief    : Two-source round-robin arbiter for a 4-digit hex display with
//            minimum dwell time and leading-zero blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_display_arbiter #(
    parameter int N     = 8,
    parameter int DWELL = 25_000_000,
    parameter bit LZB   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [2*N-1:0] data0,
    input  logic           req1,
    input  logic [2*N-1:0] data1,
    output logic           gnt0,
    output logic           gnt1,
    output logic [2*N-1:0] disp_value,
    output logic [3:0]     disp_blank,
    output logic           disp_src
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(DWELL);
    localparam int EW = (W > 16) ? W : 16;
    localparam logic [CW-1:0] c_dwell_last = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [W-1:0]    w_value_next;
    logic [EW-1:0]   w_ext;
    logic [3:0]      w_lzb;
    logic [3:0]      w_blank_next;
    logic            w_zero;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req0 && req1)
                    w_next_state = r_last ? SHOW0 : SHOW1;
                else if (req0)
                    w_next_state = SHOW0;
                else if (req1)
                    w_next_state = SHOW1;
            end
            SHOW0: begin
                if (!req0)
                    w_next_state = req1 ? SHOW1 : IDLE;
                else if (r_cnt == c_dwell_last && req1)
                    w_next_state = SHOW1;
            end
            SHOW1: begin
                if (!req1)
                    w_next_state = req0 ? SHOW0 : IDLE;
                else if (r_cnt == c_dwell_last && req0)
                    w_next_state = SHOW0;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Counter restarts on entry and on an uncontested dwell expiry, so it never wraps.
    always_comb begin
        w_cnt_next = '0;
        if (w_next_state != IDLE && w_next_state == r_state && r_cnt != c_dwell_last)
            w_cnt_next = r_cnt + CW'(1);
    end

    always_comb begin
        case (w_next_state)
            SHOW0:   w_value_next = data0;
            SHOW1:   w_value_next = data1;
            default: w_value_next = disp_value;
        endcase
    end

    // Blanking derives from the value about to be registered so both update together.
    always_comb begin
        w_ext           = '0;
        w_ext[W-1:0]    = w_value_next;
        w_zero          = 1'b1;
        w_lzb           = 4'h0;
        for (int j = 3; j >= 1; j--) begin
            if (w_ext[4*j +: 4] != 4'h0)
                w_zero = 1'b0;
            w_lzb[j] = w_zero;
        end
        if (w_next_state == IDLE)
            w_blank_next = 4'hF;
        else if (LZB)
            w_blank_next = w_lzb;
        else
            w_blank_next = 4'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            disp_value <= '0;
            disp_blank <= 4'hF;
            disp_src   <= 1'b0;
            r_last     <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_next_state;
            gnt0       <= (w_next_state == SHOW0);
            gnt1       <= (w_next_state == SHOW1);
            disp_value <= w_value_next;
            disp_blank <= w_blank_next;
            r_cnt      <= w_cnt_next;
            if (w_next_state == SHOW0) begin
                disp_src <= 1'b0;
                r_last   <= 1'b0;
            end else if (w_next_state == SHOW1) begin
                disp_src <= 1'b1;
                r_last   <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
// ============================================================================
// Module   : tb_seg_display_arbiter
// Brief    : Self-checking bench for seg_display_arbiter (DWELL=4, N=8, LZB=1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_display_arbiter;

    localparam int N     = 8;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic        gnt0, gnt1, disp_src;
    logic [15:0] disp_value;
    logic [3:0]  disp_blank;

    int errors = 0;
    int checks = 0;

    // Reference model: owner (-1 = nobody), cycles held so far, round-robin memory.
    int          m_owner = -1;
    int          m_held  = 0;
    bit          m_last  = 1'b1;
    logic [15:0] m_val   = '0;
    logic        m_src   = 1'b0;
    logic [3:0]  m_blank = 4'hF;

    seg_display_arbiter #(.N(N), .DWELL(DWELL), .LZB(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .data0      (data0),
        .req1       (req1),
        .data1      (data1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .disp_value (disp_value),
        .disp_blank (disp_blank),
        .disp_src   (disp_src)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b = 4'h0;
        for (int j = 1; j < 4; j++)
            b[j] = ((v >> (4 * j)) == 16'h0);
        return b;
    endfunction

    task automatic model_update();
        bit [1:0] rq;
        int       nxt, k, o;
        rq = {req1, req0};
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = 1'b1;
            m_val = '0; m_src = 1'b0; m_blank = 4'hF;
            return;
        end
        if (m_owner < 0) begin
            if (rq == 2'b11)      nxt = m_last ? 0 : 1;
            else if (rq[0])       nxt = 0;
            else if (rq[1])       nxt = 1;
            else                  nxt = -1;
            m_held = 1;
        end else begin
            k = m_owner;
            o = 1 - k;
            if (!rq[k]) begin
                nxt = rq[o] ? o : -1;
                m_held = 1;
            end else if (m_held >= DWELL) begin
                nxt = rq[o] ? o : k;
                m_held = 1;
            end else begin
                nxt = k;
                m_held = m_held + 1;
            end
        end
        m_owner = nxt;
        if (m_owner >= 0) begin
            m_val   = (m_owner == 1) ? data1 : data0;
            m_src   = (m_owner == 1);
            m_last  = (m_owner == 1);
            m_blank = blank_of(m_val);
        end else begin
            m_blank = 4'hF;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step();
        step();
        checks++;
        if ({gnt0, gnt1, disp_value, disp_blank, disp_src} !== {1'b0, 1'b0, 16'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset: got g0=%b g1=%b v=%h b=%b s=%b, need 0 0 0000 1111 0",
                     gnt0, gnt1, disp_value, disp_blank, disp_src);
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_single();
        req0 = 1'b1; data0 = 16'h00A5;
        step();
        checks++;
        if ({gnt0, gnt1, disp_value, disp_blank, disp_src} !== {1'b1, 1'b0, 16'h00A5, 4'b1100, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: got g0=%b g1=%b v=%h b=%b s=%b, need 1 0 00a5 1100 0",
                     gnt0, gnt1, disp_value, disp_blank, disp_src);
        end
        req0 = 1'b0;
        step();
    endtask

    task automatic test_alternate();
        bit exp_g0;
        rst = 1'b1; step(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h0042; data1 = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_g0 = ((i / 4) % 2 == 0);
            checks++;
            if (gnt0 !== exp_g0 || gnt1 !== !exp_g0) begin
                errors++;
                $display("FAIL alternate cyc%0d: got g0=%b g1=%b, need g0=%b g1=%b",
                         i, gnt0, gnt1, exp_g0, !exp_g0);
            end
            if (gnt1) begin
                checks++;
                if (disp_blank !== 4'h0 || disp_value !== 16'h1234 || disp_src !== 1'b1) begin
                    errors++;
                    $display("FAIL alternate_show1 cyc%0d: got v=%h b=%b s=%b, need 1234 0000 1",
                             i, disp_value, disp_blank, disp_src);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_early_release();
        rst = 1'b1; step(); rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 16'h0007; data1 = 16'h1234;
        step();
        step();
        req0 = 1'b0;
        step();
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || disp_value !== 16'h1234) begin
            errors++;
            $display("FAIL early_release: got g0=%b g1=%b v=%h, need 0 1 1234",
                     gnt0, gnt1, disp_value);
        end
        req1 = 1'b0;
        step();
    endtask

    task automatic test_live_update();
        rst = 1'b1; step(); rst = 1'b0;
        req0 = 1'b1; data0 = 16'h0001;
        step();
        step();
        checks++;
        if (disp_value !== 16'h0001 || disp_blank !== 4'b1110) begin
            errors++;
            $display("FAIL live_before: got v=%h b=%b, need 0001 1110", disp_value, disp_blank);
        end
        data0 = 16'h0F00;
        step();
        checks++;
        if (disp_value !== 16'h0F00 || disp_blank !== 4'b1000) begin
            errors++;
            $display("FAIL live_after: got v=%h b=%b, need 0f00 1000", disp_value, disp_blank);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL live_retain cyc%0d: got g0=%b g1=%b, need 1 0", i, gnt0, gnt1);
            end
        end
    endtask

    task automatic test_zero_idle();
        req0 = 1'b1; data0 = 16'h0000;
        step();
        checks++;
        if (disp_value !== 16'h0000 || disp_blank !== 4'b1110) begin
            errors++;
            $display("FAIL zero_value: got v=%h b=%b, need 0000 1110", disp_value, disp_blank);
        end
        data0 = 16'h0050;
        step();
        req0 = 1'b0; data0 = 16'hFFFF;
        step();
        checks++;
        if ({gnt0, gnt1, disp_value, disp_blank, disp_src} !== {1'b0, 1'b0, 16'h0050, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL idle_hold: got g0=%b g1=%b v=%h b=%b s=%b, need 0 0 0050 1111 0",
                     gnt0, gnt1, disp_value, disp_blank, disp_src);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; step(); rst = 1'b0;
        req1 = 1'b1; data1 = 16'h0ABC;
        step();
        req0 = 1'b1; data0 = 16'h0003;
        step();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got g1=%b, need 1", gnt1);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, disp_value, disp_blank, disp_src} !== {1'b0, 1'b0, 16'h0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got g0=%b g1=%b v=%h b=%b s=%b, need 0 0 0000 1111 0",
                     gnt0, gnt1, disp_value, disp_blank, disp_src);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || disp_value !== 16'h0003) begin
            errors++;
            $display("FAIL reset_mid_after: got g0=%b g1=%b v=%h, need 1 0 0003",
                     gnt0, gnt1, disp_value);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_random();
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            data0 = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            data1 = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            step();
            checks++;
            if ({gnt0, gnt1, disp_value, disp_blank, disp_src} !==
                {m_owner == 0, m_owner == 1, m_val, m_blank, m_src} || (gnt0 && gnt1)) begin
                errors++;
                $display("FAIL random cyc%0d: got g0=%b g1=%b v=%h b=%b s=%b, need %b %b %h %b %b",
                         i, gnt0, gnt1, disp_value, disp_blank, disp_src,
                         m_owner == 0, m_owner == 1, m_val, m_blank, m_src);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_early_release();
        test_live_update();
        test_zero_idle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
